// File: rtl/sramc_wb_ctrl_pkg.sv
// Shared definitions for the C-buffer SRAM writeback controller:
// controller state encoding, buffer geometry and SRAM write-enable polarity.
package sramc_wb_ctrl_pkg;

    localparam int SRAM_DEPTH = 2048;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = $clog2(SRAM_DEPTH);

    // The SRAM write enable is active low.
    localparam logic WEN_WRITE = 1'b0;
    localparam logic WEN_READ  = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ROW = 2'd1,
        WRITE    = 2'd2,
        FIN      = 2'd3
    } state_t;

endpackage

// File: rtl/sramc_port_arb.sv
// Two-requester arbiter for the single C-SRAM port. The writeback engine and
// the host alternate when both request: the host always receives the cycle
// following an issued write, otherwise the lone requester wins at once.
// Also carries the one-cycle read-valid pipeline for host reads.
module sramc_port_arb (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_wr_req,
    input  logic i_host_req,
    output logic o_wr_gnt,
    output logic o_host_gnt,
    output logic o_host_rvalid
);

    logic r_last_wr;
    logic r_rvalid;
    logic w_wr;
    logic w_host;

    // Reset masks both requesters so no SRAM access is issued in that cycle.
    assign w_wr   = i_wr_req   & ~i_rst;
    assign w_host = i_host_req & ~i_rst;

    assign o_host_gnt    = w_host & (~w_wr | r_last_wr);
    assign o_wr_gnt      = w_wr & ~o_host_gnt;
    // A read granted just before reset is dropped rather than reported.
    assign o_host_rvalid = r_rvalid & ~i_rst;

    // Remember who used the port last cycle and pipeline the read valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_wr <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            r_last_wr <= o_wr_gnt;
            r_rvalid  <= o_host_gnt;
        end
    end

endmodule

// File: rtl/sramc_wb_ctrl.sv
// C-buffer writeback controller: accepts completed result rows from the
// systolic array, serializes them into row-major SRAM writes from a
// programmable base address, and shares the SRAM port with host reads.
module sramc_wb_ctrl #(
    parameter int N      = 8,
    parameter int ADDR_W = sramc_wb_ctrl_pkg::ADDR_W,
    parameter int DATA_W = sramc_wb_ctrl_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     num_rows,
    output logic                  busy,
    output logic                  done,
    input  logic                  row_valid,
    input  logic [N*DATA_W-1:0]   row_data,
    output logic                  row_ready,
    input  logic                  host_req,
    input  logic [ADDR_W-1:0]     host_addr,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_W-1:0]     host_rdata,
    output logic                  sram_en,
    output logic                  sram_wen,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_d,
    input  logic [DATA_W-1:0]     sram_q
);
    import sramc_wb_ctrl_pkg::*;

    localparam int                CW       = $clog2(N);
    localparam logic [CW-1:0]     COL_LAST = CW'(N - 1);
    localparam logic [CW-1:0]     COL_INC  = CW'(1);
    localparam logic [ADDR_W-1:0] ROW_INC  = ADDR_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_num_rows;
    logic [ADDR_W-1:0]   r_row_idx;
    logic [CW-1:0]       r_col;
    logic [N*DATA_W-1:0] r_buf;

    logic                w_wr_req;
    logic                w_wr_gnt;
    logic                w_host_gnt;
    logic                w_last_col;
    logic [ADDR_W-1:0]   w_row_nxt;
    logic [ADDR_W-1:0]   w_wr_addr;

    assign w_wr_req   = (r_state == WRITE);
    assign w_last_col = (r_col == COL_LAST);
    assign w_row_nxt  = r_row_idx + ROW_INC;
    // N is a power of two, so row_idx*N + col is a plain concatenation;
    // truncation to ADDR_W gives the modulo-2^ADDR_W wrap.
    assign w_wr_addr  = r_base + ADDR_W'({r_row_idx, r_col});

    sramc_port_arb u_arb (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_wr_req      (w_wr_req),
        .i_host_req    (host_req),
        .o_wr_gnt      (w_wr_gnt),
        .o_host_gnt    (w_host_gnt),
        .o_host_rvalid (host_rvalid)
    );

    assign host_gnt   = w_host_gnt;
    // sram_q is already the SRAM's registered output for the granted read.
    assign host_rdata = host_rvalid ? sram_q : '0;

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode and job status outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        row_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = (num_rows == '0) ? FIN : WAIT_ROW;
            end
            WAIT_ROW: begin
                busy      = 1'b1;
                row_ready = 1'b1;
                if (row_valid) w_state_nxt = WRITE;
            end
            WRITE: begin
                busy = 1'b1;
                if (w_wr_gnt && w_last_col)
                    w_state_nxt = (w_row_nxt == r_num_rows) ? FIN : WAIT_ROW;
            end
            FIN: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // SRAM port mux: writeback element or host read, idle otherwise.
    always_comb begin
        sram_en   = 1'b0;
        sram_wen  = WEN_READ;
        sram_addr = '0;
        sram_d    = '0;
        if (w_wr_gnt) begin
            sram_en   = 1'b1;
            sram_wen  = WEN_WRITE;
            sram_addr = w_wr_addr;
            sram_d    = r_buf[r_col*DATA_W +: DATA_W];
        end else if (w_host_gnt) begin
            sram_en   = 1'b1;
            sram_wen  = WEN_READ;
            sram_addr = host_addr;
        end
    end

    // Job parameters, row/column counters and the row buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base     <= '0;
            r_num_rows <= '0;
            r_row_idx  <= '0;
            r_col      <= '0;
            r_buf      <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_base     <= base_addr;
                r_num_rows <= num_rows;
                r_row_idx  <= '0;
                r_col      <= '0;
            end
            if (r_state == WAIT_ROW && row_valid) begin
                r_buf <= row_data;
                r_col <= '0;
            end
            // A stalled write (host slot) leaves the column untouched.
            if (w_wr_gnt) begin
                r_col <= r_col + COL_INC;
                if (w_last_col) r_row_idx <= w_row_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sramc_wb_ctrl.sv
// Bench for sramc_wb_ctrl: drives writeback jobs and host reads, models the
// SRAM, and checks every port access against a queue of expected writes and
// reads derived from the job description.
module tb_sramc_wb_ctrl;

    localparam int N  = 8;
    localparam int AW = 11;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst, start, row_valid, host_req;
    logic [AW-1:0]   base_addr, num_rows, host_addr;
    logic [N*DW-1:0] row_data;
    logic            busy, done, row_ready, host_gnt, host_rvalid;
    logic            sram_en, sram_wen;
    logic [DW-1:0]   host_rdata, sram_d, sram_q;
    logic [AW-1:0]   sram_addr;

    sramc_wb_ctrl #(.N(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .busy(busy), .done(done), .row_valid(row_valid),
        .row_data(row_data), .row_ready(row_ready), .host_req(host_req),
        .host_addr(host_addr), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .sram_en(sram_en), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_d(sram_d), .sram_q(sram_q)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // SRAM model: synchronous write, read data valid the cycle after.
    logic [DW-1:0] mem [0:2047];
    always @(posedge clk) begin
        if (sram_en && !sram_wen) mem[sram_addr] <= sram_d;
        if (sram_en &&  sram_wen) sram_q <= mem[sram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference expectations.
    logic [AW-1:0] exp_wa[$];
    logic [DW-1:0] exp_wd[$];
    logic [DW-1:0] exp_rd[$];
    int  n_wr, n_done, first_wr, last_wr, done_cyc, acc_cyc;
    bit  prev_wr, prev_gnt, prev_done;

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int off);
        return AW'((int'(base) + off) % 2048);
    endfunction

    function automatic logic [N*DW-1:0] rand_row();
        logic [N*DW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    // Port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic wr;
        if (rst) begin
            prev_wr = 0; prev_gnt = 0; prev_done = 0;
        end else begin
            wr = sram_en && !sram_wen;
            if (wr) begin
                if (exp_wa.size() == 0) check("unexpected_write", 32'(sram_addr), 32'hFFFF);
                else begin
                    check("wr_addr", 32'(sram_addr), 32'(exp_wa.pop_front()));
                    check("wr_data", 32'(sram_d), 32'(exp_wd.pop_front()));
                end
                n_wr++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
            if (!sram_en) check("idle_wen", 32'(sram_wen), 32'd1);
            if (host_req) begin
                check("host_gnt_slot", 32'(host_gnt), 32'(!wr));
                if (prev_wr) check("host_after_write", 32'(wr), 32'd0);
            end else check("gnt_no_req", 32'(host_gnt), 32'd0);
            if (host_gnt) begin
                check("gnt_port", {30'd0, sram_en, sram_wen}, 32'd3);
                check("gnt_addr", 32'(sram_addr), 32'(host_addr));
                exp_rd.push_back(mem[host_addr]);
            end
            check("rvalid_latency", 32'(host_rvalid), 32'(prev_gnt));
            if (host_rvalid && exp_rd.size() > 0)
                check("rdata", 32'(host_rdata), 32'(exp_rd.pop_front()));
            if (done) begin
                n_done++;
                done_cyc = cyc;
                check("done_busy", 32'(busy), 32'd1);
            end
            if (prev_done) check("busy_fall", 32'(busy), 32'd0);
            if (row_ready) begin
                check("rr_busy", 32'(busy), 32'd1);
                check("rr_nowrite", 32'(wr), 32'd0);
                if (row_valid && acc_cyc < 0) acc_cyc = cyc;
            end
            prev_wr = wr; prev_gnt = host_gnt; prev_done = done;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_row(input logic [AW-1:0] base, input int r, input int gap,
                            input logic [N*DW-1:0] d);
        int n = 0;
        repeat (gap) tick();
        for (int k = 0; k < N; k++) begin
            exp_wa.push_back(exp_addr(base, r*N + k));
            exp_wd.push_back(d[k*DW +: DW]);
        end
        row_valid = 1'b1;
        row_data  = d;
        @(negedge clk);
        while (!row_ready && n < 200) begin @(negedge clk); n++; end
        if (!row_ready) check("row_accept_timeout", 32'd0, 32'd1);
        tick();
        row_valid = 1'b0;
    endtask

    task automatic reset_job_stats();
        n_wr = 0; n_done = 0; first_wr = -1; last_wr = -1; done_cyc = -1; acc_cyc = -1;
    endtask

    task automatic run_job(input logic [AW-1:0] base, input int rows, input int gap,
                           input bit dup_start, input bit fix0,
                           input logic [N*DW-1:0] row0, output int s_cyc);
        int n = 0;
        reset_job_stats();
        tick();
        start = 1'b1; base_addr = base; num_rows = AW'(rows); s_cyc = cyc;
        tick();
        start = 1'b0;
        for (int r = 0; r < rows; r++) begin
            push_row(base, r, gap, (fix0 && r == 0) ? row0 : rand_row());
            if (dup_start && r == 0) begin
                start = 1'b1; base_addr = base + AW'(100); num_rows = AW'(1);
                tick();
                start = 1'b0;
            end
        end
        while (n_done == 0 && n < 500) begin tick(); n++; end
        repeat (3) tick();
        check("job_done_count", 32'(n_done), 32'd1);
        check("job_write_count", 32'(n_wr), 32'(rows * N));
        check("job_writes_left", 32'(exp_wa.size()), 32'd0);
        check("job_idle_busy", 32'(busy), 32'd0);
        if (rows == 0) check("empty_done_cycle", 32'(done_cyc), 32'(s_cyc + 1));
        else begin
            check("done_after_last_write", 32'(done_cyc), 32'(last_wr + 1));
            check("first_write_after_accept", 32'(first_wr), 32'(acc_cyc + 1));
        end
    endtask

    task automatic host_read(input logic [AW-1:0] a);
        int n = 0;
        host_req = 1'b1; host_addr = a;
        @(negedge clk);
        while (!host_gnt && n < 100) begin @(negedge clk); n++; end
        if (!host_gnt) check("host_gnt_timeout", 32'd0, 32'd1);
        tick();
        host_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        bit stop_host;
        logic [AW-1:0]   b;
        logic [N*DW-1:0] d;
        logic [DW-1:0]   old [N];

        rst = 1'b1; start = 1'b0; row_valid = 1'b0; host_req = 1'b0;
        base_addr = '0; num_rows = '0; host_addr = '0; row_data = '0;
        reset_job_stats();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_row_ready", 32'(row_ready), 32'd0);
        check("rst_host_gnt", 32'(host_gnt), 32'd0);
        check("rst_host_rvalid", 32'(host_rvalid), 32'd0);
        check("rst_host_rdata", 32'(host_rdata), 32'd0);
        check("rst_sram_en", 32'(sram_en), 32'd0);
        check("rst_sram_wen", 32'(sram_wen), 32'd1);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_sram_d", 32'(sram_d), 32'd0);

        // Single row 01..08 at 0x010: eight back-to-back writes.
        for (int k = 0; k < N; k++) d[k*DW +: DW] = DW'(k + 1);
        run_job(11'h010, 1, 0, 1'b0, 1'b1, d, sc);
        check("single_row_span", 32'(last_wr - first_wr), 32'(N - 1));
        check("single_row_mem_last", 32'(mem[11'h017]), 32'h08);

        // Three rows with array stalls and an ignored second start.
        run_job(AW'($urandom_range(0, 1900)), 3, 5, 1'b1, 1'b0, '0, sc);

        // Address wrap past the top of the SRAM.
        run_job(11'h7FC, 1, 0, 1'b0, 1'b0, '0, sc);
        check("wrap_span", 32'(last_wr - first_wr), 32'(N - 1));

        // Host held on 0x005 while a row is written over it.
        tick();
        host_req = 1'b1; host_addr = 11'h005;
        run_job(11'h000, 1, 0, 1'b0, 1'b0, '0, sc);
        check("contention_span", 32'(last_wr - first_wr), 32'(2*N - 2));
        host_req = 1'b0;
        tick();

        // Empty job.
        run_job(AW'($urandom), 0, 0, 1'b0, 1'b0, '0, sc);
        check("empty_no_writes", 32'(n_wr), 32'd0);

        // Random jobs with a concurrent random host reader.
        stop_host = 1'b0;
        fork
            begin
                for (int j = 0; j < 6; j++)
                    run_job(AW'($urandom), $urandom_range(1, 3), $urandom_range(0, 4),
                            1'b0, 1'b0, '0, sc);
                stop_host = 1'b1;
            end
            begin
                while (!stop_host) begin
                    repeat ($urandom_range(0, 3)) tick();
                    host_read(AW'($urandom));
                end
            end
        join
        repeat (3) tick();
        check("reads_left", 32'(exp_rd.size()), 32'd0);

        // Reset during the fourth element write of a row.
        b = AW'($urandom);
        d = rand_row();
        for (int k = 0; k < N; k++) old[k] = mem[exp_addr(b, k)];
        reset_job_stats();
        tick();
        start = 1'b1; base_addr = b; num_rows = AW'(2);
        tick();
        start = 1'b0;
        push_row(b, 0, 0, d);
        for (int n = 0; n < 50 && n_wr < 3; n++) tick();
        check("pre_reset_writes", 32'(n_wr), 32'd3);
        rst = 1'b1; host_req = 1'b1; host_addr = AW'($urandom);
        tick();
        rst = 1'b0; host_req = 1'b0;
        exp_wa.delete(); exp_wd.delete(); exp_rd.delete();
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_row_ready", 32'(row_ready), 32'd0);
        check("mid_rst_rvalid", 32'(host_rvalid), 32'd0);
        check("mid_rst_sram", {29'd0, sram_en, sram_wen, host_gnt}, 32'd2);
        check("mid_rst_sram_addr", 32'(sram_addr), 32'd0);
        check("mid_rst_sram_d", 32'(sram_d), 32'd0);
        repeat (5) tick();
        check("mid_rst_no_done", 32'(n_done), 32'd0);
        check("mid_rst_writes", 32'(n_wr), 32'd3);
        for (int k = 0; k < N; k++)
            check("mid_rst_mem", 32'(mem[exp_addr(b, k)]),
                  32'((k < 3) ? d[k*DW +: DW] : old[k]));

        // A fresh job after the aborted one must start cleanly.
        run_job(AW'($urandom), 1, 0, 1'b0, 1'b0, '0, sc);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
